seg_display_ctrl: RTL and testbench

- Owns the 16-bit value and digit-enable mask fed to the 4-digit seven-segment driver of the lock.
- Arbitrates between two sources:
  - the live keypad entry (default source);
  - transient status messages, e.g. open/error codes, requested over a req/ack handshake and shown for a fixed hold time, optionally blinking.
- Sits between the lock FSM / keypad collector and the segment driver.

---
 rtl/seg_display_ctrl_if.sv | 21 ++
 rtl/seg_display_ctrl.sv | 127 ++++++++++++
 tb/tb_seg_display_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seg_display_ctrl_if.sv
// Message request/acknowledge channel between the lock FSM and the display controller.
interface seg_display_ctrl_if;
  logic        msg_req;
  logic [15:0] msg_code;
  logic        msg_blink;
  logic        msg_cancel;
  logic        msg_ack;
  logic        busy;

  // Requester side (lock FSM)
  modport master (
    output msg_req, msg_code, msg_blink, msg_cancel,
    input  msg_ack, busy
  );

  // Display controller side
  modport slave (
    input  msg_req, msg_code, msg_blink, msg_cancel,
    output msg_ack, busy
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Seven-segment display source arbiter.
// Shows live keypad entry by default. Accepted status messages take over the
// display for HOLD_CYC cycles and may blink with a BLINK_CYC half-period.
module seg_display_ctrl #(
  parameter int HOLD_CYC  = 100000000,
  parameter int BLINK_CYC = 25000000,
  parameter int CNT_W     = 27
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [15:0]         entry_num,
  input  logic [2:0]          entry_len,
  seg_display_ctrl_if.slave   msg,
  output logic [15:0]         num_out,
  output logic [3:0]          digit_en
);

  typedef enum logic {IDLE, MSG} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [15:0]        code_q, code_d;
  logic               blink_q, blink_d;
  logic               msg_ack_q, msg_ack_d;
  logic               busy_q, busy_d;
  logic [15:0]        num_out_q, num_out_d;
  logic [3:0]         digit_en_q, digit_en_d;
  logic [3:0]         entry_mask;

  assign msg.msg_ack = msg_ack_q;
  assign msg.busy    = busy_q;
  assign num_out     = num_out_q;
  assign digit_en    = digit_en_q;

  // Thermometer mask of lit digits; lengths above 4 saturate to all digits.
  always_comb begin
    entry_mask = 4'hF;
    case (entry_len)
      3'd0:    entry_mask = 4'h0;
      3'd1:    entry_mask = 4'h1;
      3'd2:    entry_mask = 4'h3;
      3'd3:    entry_mask = 4'h7;
      default: entry_mask = 4'hF;
    endcase
  end

  // Next-state, counters and registered display outputs.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    code_d      = code_q;
    blink_d     = blink_q;
    msg_ack_d   = 1'b0;
    num_out_d   = num_out_q;
    digit_en_d  = digit_en_q;

    // Blink timebase free-runs in both states; acceptance re-phases it below.
    if (blink_cnt_q == CNT_W'(BLINK_CYC - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CNT_W'(1);
      blink_ph_d  = blink_ph_q;
    end

    case (state_q)
      IDLE: begin
        num_out_d  = entry_num;
        digit_en_d = entry_mask;
        // Cancel suppresses any simultaneous request.
        if (msg.msg_req && !msg.msg_cancel) begin
          state_d     = MSG;
          msg_ack_d   = 1'b1;
          code_d      = msg.msg_code;
          blink_d     = msg.msg_blink;
          hold_cnt_d  = CNT_W'(HOLD_CYC - 1);
          blink_cnt_d = '0;
          blink_ph_d  = 1'b1;
        end
      end
      MSG: begin
        num_out_d  = code_q;
        digit_en_d = (!blink_q || blink_ph_q) ? 4'hF : 4'h0;
        // Expiry and cancel collapse into the same single return to IDLE.
        if (msg.msg_cancel || hold_cnt_q == '0) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MSG);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      code_q      <= '0;
      blink_q     <= 1'b0;
      msg_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      num_out_q   <= '0;
      digit_en_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      code_q      <= code_d;
      blink_q     <= blink_d;
      msg_ack_q   <= msg_ack_d;
      busy_q      <= busy_d;
      num_out_q   <= num_out_d;
      digit_en_q  <= digit_en_d;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with HOLD_CYC=8, BLINK_CYC=3.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] entry_num;
  logic [2:0]  entry_len;
  logic [15:0] num_out;
  logic [3:0]  digit_en;
  int          checks = 0;
  int          failures = 0;

  seg_display_ctrl_if mif ();

  seg_display_ctrl #(.HOLD_CYC(8), .BLINK_CYC(3), .CNT_W(27)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .entry_num (entry_num),
    .entry_len (entry_len),
    .msg       (mif.slave),
    .num_out   (num_out),
    .digit_en  (digit_en)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle 1 time unit so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] n, input logic [3:0] d,
                         input logic b, input logic a);
    chk({tag, ".num"}, num_out, n);
    chk({tag, ".den"}, {12'h0, digit_en}, {12'h0, d});
    chk({tag, ".busy"}, {15'h0, mif.busy}, {15'h0, b});
    chk({tag, ".ack"}, {15'h0, mif.msg_ack}, {15'h0, a});
  endtask

  logic [3:0] blink_exp [8];
  logic [3:0] len_exp [8];

  initial begin
    blink_exp = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
    len_exp   = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF};
    rstn = 1'b0;
    entry_num = 16'h0; entry_len = 3'd0;
    mif.msg_req = 1'b0; mif.msg_code = 16'h0; mif.msg_blink = 1'b0; mif.msg_cancel = 1'b0;

    // Reset state
    tick(); tick();
    chk_all("reset", 16'h0, 4'h0, 1'b0, 1'b0);
    rstn = 1'b1;

    // 1: entry display with one-cycle latency and length saturation
    entry_num = 16'h1234; entry_len = 3'd2;
    tick();
    chk_all("t1.len2", 16'h1234, 4'h3, 1'b0, 1'b0);
    entry_len = 3'd5;
    tick();
    chk("t1.len5", {12'h0, digit_en}, 16'h000F);
    for (int i = 0; i < 8; i++) begin
      entry_len = 3'(i);
      tick();
      chk($sformatf("t1.mask%0d", i), {12'h0, digit_en}, {12'h0, len_exp[i]});
    end

    // 2: steady message, busy exactly 8 cycles, entry changes ignored meanwhile
    entry_len = 3'd4;
    mif.msg_req = 1'b1; mif.msg_code = 16'hC0DE; mif.msg_blink = 1'b0;
    tick();
    chk_all("t2.accept", 16'h1234, 4'hF, 1'b1, 1'b1);
    mif.msg_req = 1'b0;
    entry_num = 16'h5678; entry_len = 3'd1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all($sformatf("t2.msg%0d", i), 16'hC0DE, 4'hF, (i < 8), 1'b0);
    end
    tick();
    chk_all("t2.restore", 16'h5678, 4'h1, 1'b0, 1'b0);

    // 3: blinking message, phase starts visible
    mif.msg_req = 1'b1; mif.msg_code = 16'hBEEF; mif.msg_blink = 1'b1;
    tick();
    chk_all("t3.accept", 16'h5678, 4'h1, 1'b1, 1'b1);
    mif.msg_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all($sformatf("t3.blink%0d", i), 16'hBEEF, blink_exp[i-1], (i < 8), 1'b0);
    end
    tick();
    chk_all("t3.restore", 16'h5678, 4'h1, 1'b0, 1'b0);

    // 4: request raised mid-message is held off until busy drops
    mif.msg_req = 1'b1; mif.msg_code = 16'hA111; mif.msg_blink = 1'b0;
    tick();
    chk_all("t4.accept1", 16'h5678, 4'h1, 1'b1, 1'b1);
    mif.msg_req = 1'b0;
    tick(); tick();
    mif.msg_req = 1'b1; mif.msg_code = 16'hB222;
    for (int i = 3; i <= 8; i++) begin
      tick();
      chk_all($sformatf("t4.hold%0d", i), 16'hA111, 4'hF, (i < 8), 1'b0);
    end
    tick();
    chk_all("t4.accept2", 16'h5678, 4'h1, 1'b1, 1'b1);
    mif.msg_req = 1'b0;
    // Run B222 to expiry with cancel coinciding with the final hold cycle
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("t4.b222_%0d", i), num_out, 16'hB222);
    end
    mif.msg_cancel = 1'b1;
    tick();
    chk_all("t4.expcancel", 16'hB222, 4'hF, 1'b0, 1'b0);
    mif.msg_cancel = 1'b0;
    tick();
    chk_all("t4.restore", 16'h5678, 4'h1, 1'b0, 1'b0);
    tick();
    chk_all("t4.noextra", 16'h5678, 4'h1, 1'b0, 1'b0);

    // 5: cancel on the third MSG edge
    mif.msg_req = 1'b1; mif.msg_code = 16'hC333;
    tick();
    chk_all("t5.accept", 16'h5678, 4'h1, 1'b1, 1'b1);
    mif.msg_req = 1'b0;
    tick(); tick();
    mif.msg_cancel = 1'b1;
    tick();
    chk_all("t5.cancel", 16'hC333, 4'hF, 1'b0, 1'b0);
    mif.msg_cancel = 1'b0;
    entry_num = 16'h9ABC; entry_len = 3'd3;
    tick();
    chk_all("t5.restore", 16'h9ABC, 4'h7, 1'b0, 1'b0);
    // req and cancel together in IDLE: no acceptance
    mif.msg_req = 1'b1; mif.msg_cancel = 1'b1; mif.msg_code = 16'hD444;
    tick();
    chk_all("t5.reqcan1", 16'h9ABC, 4'h7, 1'b0, 1'b0);
    tick();
    chk_all("t5.reqcan2", 16'h9ABC, 4'h7, 1'b0, 1'b0);
    mif.msg_cancel = 1'b0;
    tick();
    chk_all("t5.lateacc", 16'h9ABC, 4'h7, 1'b1, 1'b1);
    mif.msg_req = 1'b0;
    tick();
    chk_all("t5.late1", 16'hD444, 4'hF, 1'b1, 1'b0);

    // 6: asynchronous reset mid-message
    #2;
    rstn = 1'b0;
    #1;
    chk_all("t6.asyncrst", 16'h0, 4'h0, 1'b0, 1'b0);
    tick();
    chk_all("t6.inrst", 16'h0, 4'h0, 1'b0, 1'b0);
    rstn = 1'b1;
    entry_num = 16'h4321; entry_len = 3'd4;
    tick();
    chk_all("t6.release", 16'h4321, 4'hF, 1'b0, 1'b0);
    tick();
    chk_all("t6.noack", 16'h4321, 4'hF, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
